// File: rtl/ob_pkg.sv
// Shared order-book types.
// Table entries, uids and accumulated quantities.
package ob_pkg;

  typedef logic [7:0]  uid_t;
  typedef logic [15:0] price_t;
  typedef logic [15:0] quantity_t;
  typedef logic [23:0] accum_quantity_t;

  typedef struct packed {
    uid_t      uid;
    price_t    price;
    quantity_t quantity;
  } table_t;

endpackage

// File: rtl/ob_mk_table_ctl.sv
// Command sequencer for one market-side order table.
// Turns INSERT/CANCEL/QRY/POP commands into table strobes and responses.
module ob_mk_table_ctl
  import ob_pkg::*;
#(
  parameter int N           = 16,
  parameter int QRY_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_vld,
  input  logic [1:0]      cmd_op,
  input  table_t          cmd_tbl,
  input  uid_t            cmd_uid,
  output logic            cmd_rdy,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [1:0]      rsp_status,
  output table_t          rsp_tbl,
  output accum_quantity_t rsp_qty,
  output logic            tbl_insert,
  output table_t          tbl_insert_tbl,
  output logic            tbl_cancel,
  output uid_t            tbl_cancel_uid,
  input  logic            tbl_cancel_hit_w,
  input  table_t          tbl_cancel_hit_tbl_w,
  output logic            tbl_head_pop,
  input  logic            tbl_head_vld_r,
  input  table_t          tbl_head_r,
  input  logic            tbl_full_w,
  input  logic            tbl_empty_w,
  output logic            tbl_qry_vld,
  input  logic            tbl_qry_rsp_vld_r,
  input  accum_quantity_t tbl_qry_rsp_qty_r
);

  localparam int CW = $clog2(QRY_TIMEOUT) + 1;

  localparam logic [1:0] OP_INS = 2'b00;
  localparam logic [1:0] OP_CAN = 2'b01;
  localparam logic [1:0] OP_QRY = 2'b10;
  localparam logic [1:0] OP_POP = 2'b11;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_REJ = 2'b01;
  localparam logic [1:0] ST_MIS = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  if (N < 1 || QRY_TIMEOUT < 2) begin : g_param_chk
    $error("ob_mk_table_ctl: bad N or QRY_TIMEOUT");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    QWAIT,
    RSP
  } state_t;

  state_t        state;
  logic [1:0]    op_q;
  table_t        tbl_q;
  uid_t          uid_q;
  logic          full_q;
  logic          empty_q;
  logic [CW-1:0] cnt;
  logic          in_exec;
  logic          tmo_hit;
  logic          occ_unused;

  // Occupancy of the table is tracked for visibility only.
  assign occ_unused = empty_q;

  assign in_exec = (state == EXEC);
  assign tmo_hit = (cnt == CW'(QRY_TIMEOUT - 1));
  assign cmd_rdy = (state == IDLE) && !rst;

  assign tbl_insert     = in_exec && (op_q == OP_INS) && !full_q;
  assign tbl_cancel     = in_exec && (op_q == OP_CAN);
  assign tbl_head_pop   = in_exec && (op_q == OP_POP) && tbl_head_vld_r;
  assign tbl_qry_vld    = in_exec && (op_q == OP_QRY);
  assign tbl_insert_tbl = tbl_q;
  assign tbl_cancel_uid = uid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_INS;
      tbl_q      <= '0;
      uid_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      cnt        <= '0;
      rsp_vld    <= 1'b0;
      rsp_status <= ST_OK;
      rsp_tbl    <= '0;
      rsp_qty    <= '0;
    end else begin
      full_q  <= tbl_full_w;
      empty_q <= tbl_empty_w;
      unique case (state)
        IDLE: begin
          if (cmd_vld) begin
            op_q  <= cmd_op;
            tbl_q <= cmd_tbl;
            uid_q <= cmd_uid;
            state <= EXEC;
          end
        end
        EXEC: begin
          state      <= RSP;
          rsp_vld    <= 1'b1;
          rsp_status <= ST_OK;
          rsp_tbl    <= '0;
          rsp_qty    <= '0;
          unique case (1'b1)
            (op_q == OP_INS): begin
              if (full_q) rsp_status <= ST_REJ;
            end
            (op_q == OP_CAN): begin
              if (tbl_cancel_hit_w) rsp_tbl <= tbl_cancel_hit_tbl_w;
              else rsp_status <= ST_MIS;
            end
            (op_q == OP_POP): begin
              if (tbl_head_vld_r) rsp_tbl <= tbl_head_r;
              else rsp_status <= ST_REJ;
            end
            (op_q == OP_QRY): begin
              state   <= QWAIT;
              rsp_vld <= 1'b0;
              cnt     <= '0;
            end
          endcase
        end
        QWAIT: begin
          cnt <= cnt + CW'(1);
          if (tbl_qry_rsp_vld_r) begin
            rsp_qty    <= tbl_qry_rsp_qty_r;
            rsp_status <= ST_OK;
            rsp_vld    <= 1'b1;
            state      <= RSP;
          end else if (tmo_hit) begin
            rsp_qty    <= '0;
            rsp_status <= ST_TMO;
            rsp_vld    <= 1'b1;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_rdy) begin
            rsp_vld    <= 1'b0;
            rsp_status <= ST_OK;
            rsp_tbl    <= '0;
            rsp_qty    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_one_strobe: assert property (@(posedge clk) disable iff (rst)
    $onehot0({tbl_insert, tbl_cancel, tbl_head_pop, tbl_qry_vld}));

endmodule

// File: tb/tb_ob_mk_table_ctl.sv
// Scoreboard bench for ob_mk_table_ctl.
// A small table model answers strobes; a monitor checks each response.
module tb_ob_mk_table_ctl;
  import ob_pkg::*;

  localparam int N   = 16;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_vld;
  logic [1:0]      cmd_op;
  table_t          cmd_tbl;
  uid_t            cmd_uid;
  logic            cmd_rdy;
  logic            rsp_vld;
  logic            rsp_rdy;
  logic [1:0]      rsp_status;
  table_t          rsp_tbl;
  accum_quantity_t rsp_qty;
  logic            tbl_insert;
  table_t          tbl_insert_tbl;
  logic            tbl_cancel;
  uid_t            tbl_cancel_uid;
  logic            hit_w;
  table_t          hit_tbl_w;
  logic            tbl_head_pop;
  logic            head_vld;
  table_t          head;
  logic            full_w;
  logic            empty_w;
  logic            tbl_qry_vld;
  logic            qv = 1'b0;
  accum_quantity_t qq = '0;

  ob_mk_table_ctl #(.N(N), .QRY_TIMEOUT(TMO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_vld              (cmd_vld),
    .cmd_op               (cmd_op),
    .cmd_tbl              (cmd_tbl),
    .cmd_uid              (cmd_uid),
    .cmd_rdy              (cmd_rdy),
    .rsp_vld              (rsp_vld),
    .rsp_rdy              (rsp_rdy),
    .rsp_status           (rsp_status),
    .rsp_tbl              (rsp_tbl),
    .rsp_qty              (rsp_qty),
    .tbl_insert           (tbl_insert),
    .tbl_insert_tbl       (tbl_insert_tbl),
    .tbl_cancel           (tbl_cancel),
    .tbl_cancel_uid       (tbl_cancel_uid),
    .tbl_cancel_hit_w     (hit_w),
    .tbl_cancel_hit_tbl_w (hit_tbl_w),
    .tbl_head_pop         (tbl_head_pop),
    .tbl_head_vld_r       (head_vld),
    .tbl_head_r           (head),
    .tbl_full_w           (full_w),
    .tbl_empty_w          (empty_w),
    .tbl_qry_vld          (tbl_qry_vld),
    .tbl_qry_rsp_vld_r    (qv),
    .tbl_qry_rsp_qty_r    (qq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- table model ----
  table_t m_q[16];
  int     m_cnt = 0;
  int     m_ncnt;
  int     m_hit_idx;

  initial for (int i = 0; i < 16; i++) m_q[i] = '0;

  always_comb begin
    hit_w     = 1'b0;
    hit_tbl_w = '0;
    m_hit_idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (tbl_cancel && !hit_w && i < m_cnt &&
          m_q[i].uid == tbl_cancel_uid) begin
        hit_w     = 1'b1;
        hit_tbl_w = m_q[i];
        m_hit_idx = i;
      end
    end
    m_ncnt = m_cnt;
    if (tbl_insert && m_cnt < 16) m_ncnt = m_ncnt + 1;
    if (tbl_head_pop && m_cnt > 0) m_ncnt = m_ncnt - 1;
    if (hit_w) m_ncnt = m_ncnt - 1;
  end

  assign full_w   = (m_ncnt == N);
  assign empty_w  = (m_ncnt == 0);
  assign head_vld = (m_cnt > 0);
  assign head     = m_q[0];

  always @(posedge clk) begin
    table_t t[16];
    t = m_q;
    if (tbl_insert && m_cnt < 16) t[m_cnt] = tbl_insert_tbl;
    if (tbl_head_pop && m_cnt > 0)
      for (int i = 0; i < 15; i++) t[i] = t[i+1];
    if (hit_w)
      for (int i = 0; i < 15; i++) if (i >= m_hit_idx) t[i] = t[i+1];
    m_q   <= t;
    m_cnt <= m_ncnt;
  end

  // ---- count model: answers qdelay cycles after tbl_qry_vld ----
  int              qdelay = 0;
  int              qcnt = 0;
  accum_quantity_t qval = '0;

  always @(posedge clk) begin
    if (tbl_qry_vld) begin
      qv   <= 1'b0;
      qcnt <= (qdelay > 0) ? qdelay - 1 : 0;
    end else if (qcnt > 0) begin
      qcnt <= qcnt - 1;
      if (qcnt == 1) begin
        qv <= 1'b1;
        qq <= qval;
      end
    end
  end

  // ---- scoreboard and checks ----
  typedef struct {
    logic [1:0]      st;
    table_t          t;
    accum_quantity_t q;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   rsp_count = 0;
  int   n_ins, n_can, n_pop, n_qry;
  bit   seen = 0;
  int   vld_cyc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_ins += int'(tbl_insert);
      n_can += int'(tbl_cancel);
      n_pop += int'(tbl_head_pop);
      n_qry += int'(tbl_qry_vld);
      if (rsp_vld && !seen) begin
        seen    = 1;
        vld_cyc = cyc;
      end
      if (rsp_vld && rsp_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_vld), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_status", 64'(rsp_status), 64'(e.st));
          chk("rsp_tbl", 64'(rsp_tbl), 64'(e.t));
          chk("rsp_qty", 64'(rsp_qty), 64'(e.q));
        end
        seen = 0;
        rsp_count++;
      end
    end
  end

  function automatic table_t mk(int u);
    table_t t;
    t.uid      = uid_t'(u);
    t.price    = price_t'(u * 10);
    t.quantity = quantity_t'(u + 1);
    return t;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input table_t t,
                        input int uid, input logic [1:0] est,
                        input table_t et, input accum_quantity_t eq,
                        input int ei, input int ec, input int ep,
                        input int eqv, input int elat, input int hold);
    exp_t e;
    bit   ok;
    int   acc, base;
    e.st = est;
    e.t  = et;
    e.q  = eq;
    sb.push_back(e);
    if (hold > 0) rsp_rdy = 1'b0;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk); #1;
      ok = cmd_rdy;
    end
    if (!ok) begin
      chk("cmd_rdy_wait", 64'(cmd_rdy), 64'd1);
      return;
    end
    cmd_vld = 1'b1;
    cmd_op  = op;
    cmd_tbl = t;
    cmd_uid = uid_t'(uid);
    acc     = cyc;
    base    = rsp_count;
    n_ins = 0; n_can = 0; n_pop = 0; n_qry = 0;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    if (hold > 0) begin
      for (int k = 0; k < 200 && !seen; k++) @(posedge clk);
      #1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("bp_cmd_rdy", 64'(cmd_rdy), 64'd0);
        chk("bp_rsp_vld", 64'(rsp_vld), 64'd1);
      end
      rsp_rdy = 1'b1;
    end
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk); #1;
      ok = (rsp_count > base);
    end
    chk("rsp_done", 64'(ok), 64'd1);
    chk("latency", 64'(vld_cyc - acc), 64'(elat));
    chk("n_insert", 64'(n_ins), 64'(ei));
    chk("n_cancel", 64'(n_can), 64'(ec));
    chk("n_pop", 64'(n_pop), 64'(ep));
    chk("n_qry", 64'(n_qry), 64'(eqv));
  endtask

  initial begin
    rst = 1'b1;
    cmd_vld = 1'b0;
    cmd_op = 2'b00;
    cmd_tbl = '0;
    cmd_uid = '0;
    rsp_rdy = 1'b1;
    n_ins = 0; n_can = 0; n_pop = 0; n_qry = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_strobes", 64'({tbl_insert, tbl_cancel,
                            tbl_head_pop, tbl_qry_vld}), 64'd0);
    #1 rst = 1'b0;
    #1 chk("rel_cmd_rdy", 64'(cmd_rdy), 64'd1);

    // POP on empty table
    do_cmd(2'b11, '0, 0, 2'b01, '0, '0, 0, 0, 0, 0, 2, 0);
    chk("empty_q_init", 64'(dut.empty_q), 64'd1);
    // first INSERT into an empty table
    do_cmd(2'b00, mk(3), 0, 2'b00, '0, '0, 1, 0, 0, 0, 2, 0);
    chk("empty_q_after", 64'(dut.empty_q), 64'd0);
    do_cmd(2'b00, mk(5), 0, 2'b00, '0, '0, 1, 0, 0, 0, 2, 0);
    for (int i = 0; i < 14; i++)
      do_cmd(2'b00, mk(20 + i), 0, 2'b00, '0, '0, 1, 0, 0, 0, 2, 0);
    chk("full_q", 64'(dut.full_q), 64'd1);
    // 17th INSERT is rejected
    do_cmd(2'b00, mk(99), 0, 2'b01, '0, '0, 0, 0, 0, 0, 2, 0);
    // CANCEL hit, then miss under response back-pressure
    do_cmd(2'b01, '0, 5, 2'b00, mk(5), '0, 0, 1, 0, 0, 2, 0);
    do_cmd(2'b01, '0, 9, 2'b10, '0, '0, 0, 1, 0, 0, 2, 4);
    // POP with head uid 3
    do_cmd(2'b11, '0, 0, 2'b00, mk(3), '0, 0, 0, 1, 0, 2, 0);
    // QRY answered after 10 cycles
    qdelay = 10;
    qval   = 24'd1234;
    do_cmd(2'b10, '0, 0, 2'b00, '0, 24'd1234, 0, 0, 0, 1, 12, 0);
    // QRY with a silent table
    qdelay = 0;
    do_cmd(2'b10, '0, 0, 2'b11, '0, '0, 0, 0, 0, 1, TMO + 2, 0);

    // reset while waiting on a QRY
    for (int k = 0; k < 200 && !cmd_rdy; k++) begin
      @(posedge clk); #1;
    end
    cmd_vld = 1'b1;
    cmd_op  = 2'b10;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("qrst_cmd_rdy", 64'(cmd_rdy), 64'd0);
    chk("qrst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("qrst_rsp", 64'({rsp_status, rsp_tbl, rsp_qty}), 64'd0);
    chk("qrst_strobes", 64'({tbl_insert, tbl_cancel,
                             tbl_head_pop, tbl_qry_vld}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("qrel_cmd_rdy", 64'(cmd_rdy), 64'd1);
    do_cmd(2'b00, mk(7), 0, 2'b00, '0, '0, 1, 0, 0, 0, 2, 0);
    repeat (5) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("rsp_total", 64'(rsp_count), 64'd24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
